// File: rtl/ex_muldiv_iter.sv
// Iterative RV32/64 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with divide-by-zero / overflow fast paths and cancel.
module ex_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            cancel_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_sign;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_a;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] r_prod;  // product; low half doubles as quotient/dividend
  logic [XLEN-1:0]   r_rem;   // settled partial remainder

  // ---- issue decode ----
  logic            w_sgn1, w_sgn2, w_neg1, w_neg2, w_sign;
  logic [XLEN-1:0] w_mag1, w_mag2, w_fast_res;
  logic            w_div0, w_ovf, w_fast;

  assign w_sgn1 = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign w_sgn2 = op_i[2] ? ~op_i[0] : ~op_i[1];
  assign w_neg1 = w_sgn1 & rs1_i[XLEN-1];
  assign w_neg2 = w_sgn2 & rs2_i[XLEN-1];
  assign w_mag1 = w_neg1 ? -rs1_i : rs1_i;
  assign w_mag2 = w_neg2 ? -rs2_i : rs2_i;

  // Result sign: product/quotient follow both operands, remainder follows dividend
  always_comb begin
    w_sign = 1'b0;
    case (op_i)
      3'b000, 3'b001, 3'b100: w_sign = w_neg1 ^ w_neg2;
      3'b010, 3'b110:         w_sign = w_neg1;
      default:                w_sign = 1'b0;
    endcase
  end

  assign w_div0 = op_i[2] & (rs2_i == '0);
  assign w_ovf  = op_i[2] & ~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
  assign w_fast = w_div0 | w_ovf;
  // op_i[1] distinguishes remainder from quotient
  assign w_fast_res = w_div0 ? (op_i[1] ? rs1_i : {XLEN{1'b1}})
                             : (op_i[1] ? {XLEN{1'b0}} : rs1_i);

  // ---- iteration datapath ----
  logic [XLEN:0]   w_mul_sum, w_shift, w_diff;
  logic            w_ge;

  assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_shift   = {r_rem, r_prod[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_a};
  // Partial remainder is always below 2*divisor, so the top bit of the
  // difference is a clean borrow flag
  assign w_ge      = ~w_diff[XLEN];

  // ---- final fix-up ----
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_q, w_q_fix, w_r_fix, w_sel;

  assign w_prod_fix = r_sign ? -r_prod : r_prod;
  assign w_q        = r_prod[XLEN-1:0];
  assign w_q_fix    = r_sign ? -w_q : w_q;
  assign w_r_fix    = r_sign ? -r_rem : r_rem;

  // Pick the architectural result for the latched op
  always_comb begin
    w_sel = '0;
    case (r_op)
      3'b000:                 w_sel = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_sel = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_sel = w_q_fix;
      default:                w_sel = w_r_fix;
    endcase
  end

  // ---- FSM ----
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; cancel overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == LAST_IT) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (cancel_i) w_next = S_IDLE;
  end

  assign busy_o = (r_state != S_IDLE);
  assign done_o = (r_state == S_DONE) & ~cancel_i;

  // Operand latch, per-bit iteration and result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i && !cancel_i) begin
          r_op   <= op_i;
          r_rd   <= rd_i;
          r_sign <= w_sign;
          r_cnt  <= '0;
          r_rem  <= '0;
          r_a    <= op_i[2] ? w_mag2 : w_mag1;
          r_prod <= {{XLEN{1'b0}}, (op_i[2] ? w_mag1 : w_mag2)};
          if (w_fast) begin
            result_o <= w_fast_res;
            rd_o     <= rd_i;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op[2]) begin
            r_rem              <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_prod[XLEN-1:0]   <= {r_prod[XLEN-2:0], w_ge};
          end else begin
            r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
          end
        end
        S_FIX: if (!cancel_i) begin
          result_o <= w_sel;
          rd_o     <= r_rd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: directed table, hand sequences for cancel/reset,
// randomized ops against an arithmetic reference, plus an XLEN=64 instance.
module tb_ex_muldiv_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        start32, cancel32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] rs1_32, rs2_32, res32;
  logic [4:0]  rd32, rdo32;

  ex_muldiv_iter #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .cancel_i(cancel32), .op_i(op32),
    .rs1_i(rs1_32), .rs2_i(rs2_32), .rd_i(rd32), .busy_o(busy32), .done_o(done32),
    .result_o(res32), .rd_o(rdo32));

  // XLEN=64 instance
  logic        start64, cancel64, busy64, done64;
  logic [2:0]  op64;
  logic [63:0] rs1_64, rs2_64, res64;
  logic [4:0]  rd64, rdo64;

  ex_muldiv_iter #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .start_i(start64), .cancel_i(cancel64), .op_i(op64),
    .rs1_i(rs1_64), .rs2_i(rs2_64), .rd_i(rd64), .busy_o(busy64), .done_o(done64),
    .result_o(res64), .rd_o(rdo64));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: exact arithmetic from the RISC-V definitions
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic sa, sb, ovf;
    sa  = (op == 3'd1) || (op == 3'd2);
    sb  = (op == 3'd1);
    ea  = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb  = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p   = ea * eb;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one op on the 32-bit unit; optionally re-pulse start while busy at cycle 'poke'
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int poke,
                       output logic [31:0] res, output logic [4:0] rdv,
                       output int lat, output int bsy);
    @(negedge clk);
    op32 = op; rs1_32 = a; rs2_32 = b; rd32 = rd; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; lat = 1; bsy = 0;
    while (!done32 && lat < 200) begin
      if (busy32) bsy++;
      if (lat == poke) begin
        start32 = 1'b1; op32 = 3'b101; rs1_32 = $urandom; rs2_32 = 32'd1; rd32 = 5'd31;
      end else start32 = 1'b0;
      @(negedge clk);
      lat++;
    end
    start32 = 1'b0;
    if (busy32) bsy++;
    res = res32; rdv = rdo32;
  endtask

  task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, output logic [63:0] res, output int lat);
    @(negedge clk);
    op64 = op; rs1_64 = a; rs2_64 = b; rd64 = rd; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0; lat = 1;
    while (!done64 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    res = res64;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    bit          fast;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [31:0] r, a, b, held;
    logic [4:0]  rv, rd;
    logic [2:0]  op;
    logic [63:0] r64;
    int lat, bsy, npulse;

    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vt[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vt[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vt[6]  = '{3'd5, 32'd7,          32'd2,         32'd3,         1'b0};
    vt[7]  = '{3'd7, 32'd7,          32'd2,         32'd1,         1'b0};
    vt[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vt[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1'b1};
    vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vt[12] = '{3'd0, 32'h8000_0000,  32'h8000_0000, 32'd0,         1'b0};

    rst = 1'b1;
    start32 = 0; cancel32 = 0; op32 = 0; rs1_32 = 0; rs2_32 = 0; rd32 = 0;
    start64 = 0; cancel64 = 0; op64 = 0; rs1_64 = 0; rs2_64 = 0; rd64 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_res",  res32,  0);
    chk("rst_rd",   rdo32,  0);
    chk("rst_res64", res64, 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run32(vt[i].op, vt[i].a, vt[i].b, 5'd17, -1, r, rv, lat, bsy);
      chk($sformatf("vec%0d_res", i), r, vt[i].exp);
      chk($sformatf("vec%0d_rd", i), rv, 5'd17);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].fast ? 1 : 34);
      chk($sformatf("vec%0d_busy", i), bsy, vt[i].fast ? 1 : 34);
      @(negedge clk);
      chk($sformatf("vec%0d_done_off", i), done32, 0);
      chk($sformatf("vec%0d_idle", i), busy32, 0);
    end

    // Random ops, corner operands mixed in
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000; 1: a = 32'hFFFF_FFFF; 2: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'h0; 1: b = 32'hFFFF_FFFF; 2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      rd = 5'($urandom);
      run32(op, a, b, rd, -1, r, rv, lat, bsy);
      chk($sformatf("rnd%0d_op%0d_res", i, op), r, ref32(op, a, b));
      chk($sformatf("rnd%0d_rd", i), rv, rd);
      chk($sformatf("rnd%0d_lat", i), lat, is_fast(op, a, b) ? 1 : 34);
    end

    // start while busy is ignored; rd/op not relatched
    run32(3'd0, 32'd3, 32'd5, 5'd4, 5, r, rv, lat, bsy);
    chk("busy_start_res", r, 32'd15);
    chk("busy_start_rd", rv, 5'd4);
    chk("busy_start_lat", lat, 34);
    held = r;

    // cancel at edge 10 of a DIVU
    @(negedge clk);
    op32 = 3'd5; rs1_32 = 32'd50; rs2_32 = 32'd3; rd32 = 5'd9; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    cancel32 = 1'b1;
    @(negedge clk);
    cancel32 = 1'b0;
    chk("cancel_busy", busy32, 0);
    chk("cancel_done", done32, 0);
    chk("cancel_res", res32, held);
    chk("cancel_rd", rdo32, 5'd4);
    npulse = 0;
    repeat (40) begin @(negedge clk); if (done32) npulse++; end
    chk("cancel_no_done", npulse, 0);

    // start + cancel together in IDLE: dropped
    start32 = 1'b1; cancel32 = 1'b1; op32 = 3'd3; rs1_32 = 32'd9; rs2_32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0; cancel32 = 1'b0;
    chk("stcan_busy", busy32, 0);
    npulse = 0;
    repeat (40) begin @(negedge clk); if (done32 || busy32) npulse++; end
    chk("stcan_no_activity", npulse, 0);
    chk("stcan_res", res32, held);

    // cancel during DONE suppresses done_o; result already registered
    op32 = 3'd5; rs1_32 = 32'd77; rs2_32 = 32'd0; rd32 = 5'd12; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    chk("cdone_busy", busy32, 1);
    cancel32 = 1'b1;
    #1;
    chk("cdone_done", done32, 0);
    chk("cdone_res", res32, 32'hFFFF_FFFF);
    @(negedge clk);
    cancel32 = 1'b0;
    chk("cdone_idle", busy32, 0);

    // reset pulse mid-operation
    op32 = 3'd0; rs1_32 = 32'd7; rs2_32 = 32'd3; rd32 = 5'd2; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy32, 0);
    chk("mrst_done", done32, 0);
    chk("mrst_res", res32, 0);
    chk("mrst_rd", rdo32, 0);
    @(negedge clk);
    rst = 1'b0;
    run32(3'd7, 32'd23, 32'd5, 5'd6, -1, r, rv, lat, bsy);
    chk("post_rst_res", r, 32'd3);

    // XLEN=64
    run64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, r64, lat);
    chk("x64_mulhu", r64, 64'd1);
    chk("x64_lat", lat, 66);
    chk("x64_rd", rdo64, 5'd1);
    run64(3'd5, 64'd100, 64'd7, 5'd2, r64, lat);
    chk("x64_divu", r64, 64'd14);
    run64(3'd0, 64'h1_0000_0001, 64'd3, 5'd3, r64, lat);
    chk("x64_mul_b2b", r64, 64'h3_0000_0003);
    chk("x64_mul_rd", rdo64, 5'd3);
    run64(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, r64, lat);
    chk("x64_rem", r64, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
